// File: rtl/romulus_pkg.sv
// ============================================================================
// Module : romulus_pkg
// Brief  : Shared constants, FSM encoding and keep-mask helper for the
//          state unload path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package romulus_pkg;

  localparam int unsigned STATE_W        = 128;
  localparam int unsigned BUS_W          = 32;
  localparam int unsigned BYTES_PER_WORD = BUS_W / 8;
  localparam int unsigned NBYTES_W       = $clog2(STATE_W / 8) + 1;
  localparam int unsigned MAX_KEEP       = 64;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Top min(cnt, bpw) bits of a bpw-wide field set; returned right-aligned.
  function automatic logic [MAX_KEEP-1:0] keep_mask(input int unsigned cnt,
                                                    input int unsigned bpw);
    logic [MAX_KEEP-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_KEEP; i++) begin
      if (i < bpw && i < cnt) m[bpw-1-i] = 1'b1;
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/state_unload_clk_gate_latch.sv
// ============================================================================
// Module : clk_gate_latch
// Brief  : Latch-based clock gate; enable captured while clk is low.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_gate_latch (
  input  logic clk,
  input  logic en,
  output logic gclk
);

  logic r_en_lat;

  always_latch begin
    if (!clk) r_en_lat <= en;
  end

  assign gclk = r_en_lat & clk;

endmodule

`default_nettype wire

// File: rtl/state_unload.sv
// ============================================================================
// Module : state_unload
// Brief  : Snapshots the cipher state and streams it MSW-first onto a narrow
//          valid/ready bus with byte-keep masking of a partial last word.
//          Define STATE_UNLOAD_CG_EN for a clock-gated shadow register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module state_unload
  import romulus_pkg::*;
#(
  parameter int unsigned WIDTH = STATE_W,
  parameter int unsigned BUS   = BUS_W,
  localparam int unsigned NB_W = $clog2(WIDTH / 8) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [WIDTH-1:0]   si,
  input  logic [NB_W-1:0]    nbytes,
  output logic               busy,
  output logic               done,
  output logic [BUS-1:0]     do_data,
  output logic [BUS/8-1:0]   do_keep,
  output logic               do_valid,
  output logic               do_last,
  input  logic               do_ready
);

  localparam int unsigned      BPW       = BUS / 8;
  localparam logic [NB_W-1:0]  MAX_BYTES = NB_W'(WIDTH / 8);
  localparam logic [NB_W-1:0]  BPW_N     = NB_W'(BPW);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_shadow;
  logic [NB_W-1:0]  r_rem;
  logic             r_done;

  logic             w_idle;
  logic             w_accept;
  logic             w_zero;
  logic             w_xfer;
  logic             w_last;
  logic             w_shadow_en;
  logic [NB_W-1:0]  w_rem_load;
  logic [WIDTH-1:0] w_shadow_d;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_accept    = w_idle & load & (nbytes != '0);
  assign w_zero      = w_idle & load & (nbytes == '0);
  assign w_xfer      = do_valid & do_ready;
  assign w_last      = (r_rem <= BPW_N);
  assign w_rem_load  = (nbytes > MAX_BYTES) ? MAX_BYTES : nbytes;
  assign w_shadow_en = w_accept | w_xfer;
  assign w_shadow_d  = w_accept ? si : (r_shadow << BUS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_zero | (w_xfer & w_last);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_SHIFT;
            r_rem   <= w_rem_load;
          end
        end
        ST_SHIFT: begin
          if (w_xfer) begin
            r_rem <= (r_rem > BPW_N) ? (r_rem - BPW_N) : '0;
            if (w_last) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef STATE_UNLOAD_CG_EN
  logic w_gclk;

  clk_gate_latch u_cg (
    .clk  (clk),
    .en   (w_shadow_en),
    .gclk (w_gclk)
  );

  always_ff @(posedge w_gclk or negedge rst_n) begin
    if (!rst_n) r_shadow <= '0;
    else        r_shadow <= w_shadow_d;
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_shadow <= '0;
    else if (w_shadow_en) r_shadow <= w_shadow_d;
  end
`endif

  assign busy     = (r_state == ST_SHIFT);
  assign do_valid = (r_state == ST_SHIFT);
  assign done     = r_done;
  assign do_last  = do_valid & w_last;
  assign do_keep  = do_valid ? BPW'(keep_mask(32'(r_rem), BPW)) : '0;

  // Bytes outside the keep mask are forced to zero on the bus.
  generate
    for (genvar b = 0; b < BPW; b++) begin : g_mask
      assign do_data[BUS-1-8*b -: 8] = r_shadow[WIDTH-1-8*b -: 8] & {8{do_keep[BPW-1-b]}};
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_state_unload.sv
// ============================================================================
// Module : tb_state_unload
// Brief  : Directed self-checking bench for state_unload (128-bit state,
//          32-bit bus).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_state_unload;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic [127:0] si = '0;
  logic [4:0]   nbytes = '0;
  logic         do_ready = 1'b0;
  logic         busy, done, do_valid, do_last;
  logic [31:0]  do_data;
  logic [3:0]   do_keep;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [127:0] SI_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] SI_B = 128'hA1A2A3A4_B1B2B3B4_C1C2C3C4_D1D2D3D4;

  logic [31:0] wa [4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};

  state_unload dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .si       (si),
    .nbytes   (nbytes),
    .busy     (busy),
    .done     (done),
    .do_data  (do_data),
    .do_keep  (do_keep),
    .do_valid (do_valid),
    .do_last  (do_last),
    .do_ready (do_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input logic [127:0] s, input logic [4:0] nb);
    si = s;
    nbytes = nb;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({busy, done, do_valid, do_last, do_keep, do_data} !== 40'h0)
      $display("FAIL reset_state: got busy=%b done=%b v=%b l=%b keep=%h data=%h, want all 0",
               busy, done, do_valid, do_last, do_keep, do_data);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full(input logic [4:0] nb);
    do_ready = 1'b1;
    start_block(SI_A, nb);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({busy, do_valid, do_last, do_keep, do_data} !== {1'b1, 1'b1, (k == 3), 4'hF, wa[k]})
        $display("FAIL full_word%0d nb=%0d: got b=%b v=%b l=%b keep=%h data=%h, want data=%h keep=f last=%0d",
                 k, nb, busy, do_valid, do_last, do_keep, do_data, wa[k], (k == 3));
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({done, do_valid, busy} !== 3'b100)
      $display("FAIL full_done nb=%0d: got done=%b v=%b busy=%b, want 1 0 0", nb, done, do_valid, busy);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b0) $display("FAIL full_done_pulse nb=%0d: got done=%b, want 0", nb, done);
    else n_pass++;
  endtask

  task automatic test_partial();
    do_ready = 1'b1;
    start_block(SI_A, 5'd5);
    n_checks++;
    if ({do_valid, do_last, do_keep, do_data} !== {1'b1, 1'b0, 4'hF, 32'h00112233})
      $display("FAIL partial_w0: got v=%b l=%b keep=%h data=%h, want 1 0 f 00112233",
               do_valid, do_last, do_keep, do_data);
    else n_pass++;
    tick();
    n_checks++;
    if ({do_valid, do_last, do_keep, do_data} !== {1'b1, 1'b1, 4'h8, 32'h44000000})
      $display("FAIL partial_w1: got v=%b l=%b keep=%h data=%h, want 1 1 8 44000000",
               do_valid, do_last, do_keep, do_data);
    else n_pass++;
    tick();
    n_checks++;
    if ({done, do_valid, do_keep, do_data} !== {1'b1, 1'b0, 4'h0, 32'h0})
      $display("FAIL partial_done: got done=%b v=%b keep=%h data=%h, want 1 0 0 0",
               done, do_valid, do_keep, do_data);
    else n_pass++;
    tick();
  endtask

  task automatic test_stall();
    int k;
    k = 0;
    do_ready = 1'b1;
    start_block(SI_A, 5'd16);
    for (int c = 0; c < 20 && k < 4; c++) begin
      do_ready = (c % 3 == 0);
      n_checks++;
      if ({do_valid, do_last, do_keep, do_data} !== {1'b1, (k == 3), 4'hF, wa[k]})
        $display("FAIL stall_c%0d: got v=%b l=%b keep=%h data=%h, want word%0d=%h",
                 c, do_valid, do_last, do_keep, do_data, k, wa[k]);
      else n_pass++;
      tick();
      if (do_ready) k++;
    end
    do_ready = 1'b1;
    n_checks++;
    if ({k == 4, done, do_valid} !== 3'b110)
      $display("FAIL stall_end: got words=%0d done=%b v=%b, want 4 1 0", k, done, do_valid);
    else n_pass++;
    tick();
  endtask

  task automatic test_zero_sat();
    start_block(SI_A, 5'd0);
    n_checks++;
    if ({done, do_valid, busy} !== 3'b100)
      $display("FAIL zero_done: got done=%b v=%b busy=%b, want 1 0 0", done, do_valid, busy);
    else n_pass++;
    tick();
    n_checks++;
    if ({done, do_valid, busy} !== 3'b000)
      $display("FAIL zero_after: got done=%b v=%b busy=%b, want 0 0 0", done, do_valid, busy);
    else n_pass++;
    test_full(5'd20);
  endtask

  task automatic test_back_to_back();
    do_ready = 1'b1;
    start_block(SI_A, 5'd16);
    si = SI_B;
    nbytes = 5'd5;
    load = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({do_valid, do_last, do_keep, do_data} !== {1'b1, (k == 3), 4'hF, wa[k]})
        $display("FAIL b2b_orig_w%0d: got v=%b l=%b keep=%h data=%h, want %h",
                 k, do_valid, do_last, do_keep, do_data, wa[k]);
      else n_pass++;
      tick();
      load = 1'b0;
    end
    n_checks++;
    if ({done, do_valid} !== 2'b10)
      $display("FAIL b2b_done: got done=%b v=%b, want 1 0", done, do_valid);
    else n_pass++;
    start_block(SI_B, 5'd5);
    n_checks++;
    if ({done, do_valid, do_last, do_keep, do_data} !== {1'b0, 1'b1, 1'b0, 4'hF, 32'hA1A2A3A4})
      $display("FAIL b2b_second_w0: got done=%b v=%b l=%b keep=%h data=%h, want 0 1 0 f a1a2a3a4",
               done, do_valid, do_last, do_keep, do_data);
    else n_pass++;
    tick();
    n_checks++;
    if ({do_valid, do_last, do_keep, do_data} !== {1'b1, 1'b1, 4'h8, 32'hB1000000})
      $display("FAIL b2b_second_w1: got v=%b l=%b keep=%h data=%h, want 1 1 8 b1000000",
               do_valid, do_last, do_keep, do_data);
    else n_pass++;
    tick();
    n_checks++;
    if (done !== 1'b1) $display("FAIL b2b_second_done: got done=%b, want 1", done);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_midstream();
    do_ready = 1'b1;
    start_block(SI_A, 5'd16);
    tick();
    tick();
    n_checks++;
    if (do_data !== 32'h8899AABB)
      $display("FAIL mid_pre_reset: got data=%h, want 8899aabb", do_data);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, do_valid, do_last, do_keep, do_data} !== 40'h0)
      $display("FAIL mid_async_reset: got b=%b done=%b v=%b l=%b keep=%h data=%h, want all 0",
               busy, done, do_valid, do_last, do_keep, do_data);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({done, do_valid} !== 2'b00)
      $display("FAIL mid_no_done: got done=%b v=%b, want 0 0", done, do_valid);
    else n_pass++;
    start_block(SI_B, 5'd5);
    n_checks++;
    if ({do_valid, do_last, do_keep, do_data} !== {1'b1, 1'b0, 4'hF, 32'hA1A2A3A4})
      $display("FAIL mid_restart: got v=%b l=%b keep=%h data=%h, want 1 0 f a1a2a3a4",
               do_valid, do_last, do_keep, do_data);
    else n_pass++;
    tick();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_full(5'd16);
    test_partial();
    test_stall();
    test_zero_sat();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
